// File: rtl/ps2_ascii_rx_fifo.sv
// PS/2 set-2 keyboard receiver: filters the PS/2 clock, deframes scan codes,
// drops break/extended codes, translates make codes to ASCII and queues them for the CPU.
module ps2_ascii_rx_fifo #(
   parameter logic [7:0] KBD_PORT    = 8'h02,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         FILT_LEN    = 8,
   parameter int         TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2data,
   input  logic       ps2clk,
   input  logic [7:0] port_id,
   input  logic       read_strobe,
   output logic [7:0] ascii_code,
   output logic       key_avail,
   output logic       parity_err,
   output logic       overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = $clog2(FILT_LEN);
   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   logic [1:0]    clk_sync, data_sync;
   logic          filt_clk, fall;
   logic [FW-1:0] filt_cnt;
   logic          sclk, sdata;
   rx_state_t     state, state_nxt;
   logic [TW-1:0] to_cnt;
   logic          timeout;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift, rx_byte;
   logic          par_bit, rx_valid, frame_ok, frame_err;
   logic          brk, ext, push_valid;
   logic [7:0]    push_data;
   logic [8:0]    map;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          pop_strobe, pop, push, full;

   assign sclk  = clk_sync[1];
   assign sdata = data_sync[1];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         filt_clk  <= 1'b1;
         filt_cnt  <= '0;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2clk};
         data_sync <= {data_sync[0], ps2data};
         fall      <= 1'b0;
         if (sclk == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_clk <= sclk;
            filt_cnt <= '0;
            fall     <= filt_clk;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign timeout   = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));
   assign frame_ok  = sdata && (^{shift, par_bit});
   assign frame_err = fall && (state == STOP) && !frame_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: always_comb assigns every output a default first so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      if (fall) begin
         case (state)
            IDLE:    if (!sdata) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            default: state_nxt = IDLE;
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt   <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE || fall) to_cnt <= '0;
         else                       to_cnt <= to_cnt + 1'b1;
         if (fall) begin
            case (state)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shift   <= {sdata, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: par_bit <= sdata;
               STOP: begin
                  rx_valid <= frame_ok;
                  rx_byte  <= shift;
               end
               default: ;
            endcase
         end
      end
   end

   // {hit, ascii} for a set-2 make code.
   function automatic logic [8:0] to_ascii(input logic [7:0] code);
      case (code)
         8'h45: return {1'b1, 8'h30};  8'h16: return {1'b1, 8'h31};
         8'h1E: return {1'b1, 8'h32};  8'h26: return {1'b1, 8'h33};
         8'h25: return {1'b1, 8'h34};  8'h2E: return {1'b1, 8'h35};
         8'h36: return {1'b1, 8'h36};  8'h3D: return {1'b1, 8'h37};
         8'h3E: return {1'b1, 8'h38};  8'h46: return {1'b1, 8'h39};
         8'h1C: return {1'b1, 8'h41};  8'h32: return {1'b1, 8'h42};
         8'h21: return {1'b1, 8'h43};  8'h23: return {1'b1, 8'h44};
         8'h24: return {1'b1, 8'h45};  8'h2B: return {1'b1, 8'h46};
         8'h34: return {1'b1, 8'h47};  8'h33: return {1'b1, 8'h48};
         8'h43: return {1'b1, 8'h49};  8'h3B: return {1'b1, 8'h4A};
         8'h42: return {1'b1, 8'h4B};  8'h4B: return {1'b1, 8'h4C};
         8'h3A: return {1'b1, 8'h4D};  8'h31: return {1'b1, 8'h4E};
         8'h44: return {1'b1, 8'h4F};  8'h4D: return {1'b1, 8'h50};
         8'h15: return {1'b1, 8'h51};  8'h2D: return {1'b1, 8'h52};
         8'h1B: return {1'b1, 8'h53};  8'h2C: return {1'b1, 8'h54};
         8'h3C: return {1'b1, 8'h55};  8'h2A: return {1'b1, 8'h56};
         8'h1D: return {1'b1, 8'h57};  8'h22: return {1'b1, 8'h58};
         8'h35: return {1'b1, 8'h59};  8'h1A: return {1'b1, 8'h5A};
         8'h29: return {1'b1, 8'h20};  8'h5A: return {1'b1, 8'h0D};
         8'h66: return {1'b1, 8'h08};
         default: return 9'h000;
      endcase
   endfunction

   assign map = to_ascii(rx_byte);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         brk        <= 1'b0;
         ext        <= 1'b0;
         push_valid <= 1'b0;
         push_data  <= '0;
      end else begin
         push_valid <= 1'b0;
         if (rx_valid) begin
            if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               brk <= 1'b0;
               ext <= 1'b0;
               if (!brk && !ext && map[8]) begin
                  push_valid <= 1'b1;
                  push_data  <= map[7:0];
               end
            end
         end
      end
   end

   // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
   assign pop_strobe = (port_id == KBD_PORT) && read_strobe;
   assign pop        = pop_strobe && (count != '0);
   assign full       = (count == CW'(FIFO_DEPTH));
   assign push       = push_valid && (!full || pop);

   // NOTE: the storage array is not reset; occupancy comes only from count, so stale data is never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         parity_err <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (frame_err)       parity_err <= 1'b1;
         else if (pop_strobe) parity_err <= 1'b0;
         if (push_valid && !push) overflow <= 1'b1;
         else if (pop_strobe)     overflow <= 1'b0;
      end
   end

   assign key_avail  = (count != '0);
   assign ascii_code = key_avail ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_ascii_rx_fifo.sv
// Directed bench for ps2_ascii_rx_fifo; PS/2 timing is scaled down (bit period 40 clocks,
// timeout 500 clocks) so the whole run stays short.
module tb_ps2_ascii_rx_fifo;

   localparam int HALF    = 20;
   localparam int TIMEOUT = 500;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2data, ps2clk;
   logic [7:0] port_id;
   logic       read_strobe;
   logic [7:0] ascii_code;
   logic       key_avail, parity_err, overflow;

   int tests = 0;
   int fails = 0;

   ps2_ascii_rx_fifo #(
      .KBD_PORT(8'h02), .FIFO_DEPTH(4), .FILT_LEN(8), .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .ps2data(ps2data), .ps2clk(ps2clk),
      .port_id(port_id), .read_strobe(read_strobe), .ascii_code(ascii_code),
      .key_avail(key_avail), .parity_err(parity_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives the first nbits of a start/data/parity/stop frame; par_flip corrupts parity.
   task automatic ps2_bits(input logic [7:0] code, input logic par_flip, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^code) ^ par_flip, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2clk = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] code);
      ps2_bits(code, 1'b0, 11);
      repeat (60) @(negedge clk);
   endtask

   task automatic port_read(input logic [7:0] port);
      @(negedge clk);
      port_id     = port;
      read_strobe = 1'b1;
      @(negedge clk);
      read_strobe = 1'b0;
      port_id     = 8'h00;
   endtask

   initial begin
      reset = 1'b1; ps2data = 1'b1; ps2clk = 1'b1; port_id = 8'h00; read_strobe = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ascii", ascii_code, 8'h00);
      check("rst_avail", key_avail, 1'b0);
      check("rst_perr", parity_err, 1'b0);
      check("rst_ovf", overflow, 1'b0);

      // Single make code, then pop
      send(8'h1C);
      check("a_avail", key_avail, 1'b1);
      check("a_ascii", ascii_code, 8'h41);
      port_read(8'h03);
      check("wrong_port_keeps", ascii_code, 8'h41);
      port_read(8'h02);
      check("a_pop_avail", key_avail, 1'b0);
      check("a_pop_ascii", ascii_code, 8'h00);

      // Break sequence suppressed
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'h45);
      check("brk_count", dut.count, 3'd2);
      check("brk_head0", ascii_code, 8'h41);
      port_read(8'h02);
      check("brk_head1", ascii_code, 8'h30);
      port_read(8'h02);
      check("brk_empty", key_avail, 1'b0);

      // Extended prefix suppresses the next code
      send(8'hE0); send(8'h5A);
      check("ext_dropped", key_avail, 1'b0);

      // Bad parity
      ps2_bits(8'h1C, 1'b1, 11);
      repeat (60) @(negedge clk);
      check("par_avail", key_avail, 1'b0);
      check("par_err", parity_err, 1'b1);
      port_read(8'h02);
      check("par_clr", parity_err, 1'b0);
      check("par_count", dut.count, 3'd0);

      // Overflow
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
      check("ovf_count", dut.count, 3'd4);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_head0", ascii_code, 8'h31);
      port_read(8'h02);
      check("ovf_clr", overflow, 1'b0);
      check("ovf_head1", ascii_code, 8'h32);
      port_read(8'h02);
      check("ovf_head2", ascii_code, 8'h33);
      port_read(8'h02);
      check("ovf_head3", ascii_code, 8'h34);
      port_read(8'h02);
      check("ovf_empty", ascii_code, 8'h00);
      port_read(8'h02);
      check("pop_empty_count", dut.count, 3'd0);

      // Mid-frame timeout
      ps2_bits(8'h1C, 1'b0, 5);
      ps2data = 1'b1;
      repeat (20) @(negedge clk);
      check("to_in_data", 32'(dut.state), 32'd1);
      repeat (TIMEOUT + 300) @(negedge clk);
      check("to_idle", 32'(dut.state), 32'd0);
      check("to_nopush", key_avail, 1'b0);
      check("to_noerr", parity_err, 1'b0);
      send(8'h5A);
      check("to_next", ascii_code, 8'h0D);
      port_read(8'h02);

      // Reset mid-frame with entries queued
      send(8'h16); send(8'h1E);
      check("rq_count", dut.count, 3'd2);
      ps2_bits(8'h1C, 1'b0, 4);
      reset = 1'b1;
      #1;
      check("rq_ascii", ascii_code, 8'h00);
      check("rq_avail", key_avail, 1'b0);
      check("rq_perr", parity_err, 1'b0);
      check("rq_ovf", overflow, 1'b0);
      ps2data = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      send(8'h29);
      check("rq_next", ascii_code, 8'h20);
      check("rq_next_count", dut.count, 3'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
